// File: rtl/ifetch_pkg.sv
// Shared state encoding and default widths for the instruction fetch stage.
package ifetch_pkg;

    localparam int unsigned ADDR_WIDTH_DEF  = 8;
    localparam int unsigned INSTR_WIDTH_DEF = 16;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        DONE
    } state_e;

    // Occupancy counters need one extra bit so they can represent "full".
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ifetch_buffer.sv
// Prefetch FIFO: power-of-two depth, synchronous flush, push+pop legal when full.
module ifetch_buffer
    import ifetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = INSTR_WIDTH_DEF,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = cnt_width(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_W'(DEPTH));
    assign count     = count_q;
    assign head_data = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        do_pop   = pop & ~empty;
        // A pop in the same cycle frees the slot the push lands in.
        do_push  = push & (~full | do_pop);
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: PC sequencing over a 1-cycle ROM, prefetch buffer, run/stop,
// end address and redirect. Define IFETCH_RETIRE_COUNT_EN to add retire_count.
module instruction_fetch
    import ifetch_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter int unsigned INSTR_WIDTH = INSTR_WIDTH_DEF,
    parameter int unsigned BUF_DEPTH   = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   run,
    input  logic [ADDR_WIDTH-1:0]  end_addr,
    input  logic                   redirect_valid,
    input  logic [ADDR_WIDTH-1:0]  redirect_addr,
    output logic                   mem_rd_en,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    input  logic [INSTR_WIDTH-1:0] mem_rdata,
    output logic [INSTR_WIDTH-1:0] iin,
    output logic                   iin_valid,
    input  logic                   iin_ready,
    output logic [ADDR_WIDTH-1:0]  pc,
`ifdef IFETCH_RETIRE_COUNT_EN
    output logic [15:0]            retire_count,
`endif
    output logic                   done
);

    localparam int unsigned CNT_W = cnt_width(BUF_DEPTH);

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic                   inflight_q, inflight_d;
    logic                   rd_en, fill, pop;
    logic [CNT_W:0]         occupancy;
    logic [CNT_W-1:0]       buf_count;
    logic                   buf_full, buf_empty;
    logic [INSTR_WIDTH-1:0] buf_head;

    ifetch_buffer #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (INSTR_WIDTH)
    ) u_buffer (
        .clock     (clock),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (fill),
        .push_data (mem_rdata),
        .pop       (pop),
        .head_data (buf_head),
        .count     (buf_count),
        .full      (buf_full),
        .empty     (buf_empty)
    );

    assign iin_valid = ~buf_empty;
    assign iin       = buf_empty ? '0 : buf_head;
    assign mem_rd_en = rd_en;
    assign mem_addr  = pc_q;
    assign pc        = pc_q;
    assign done      = (state_q == DONE);
    assign occupancy = {1'b0, buf_count} + {{CNT_W{1'b0}}, inflight_q};

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        rd_en   = 1'b0;
        // Redirect kills the returning word and drops any coincident pop.
        fill    = inflight_q & ~redirect_valid;
        pop     = iin_valid & iin_ready & ~redirect_valid;
        if (redirect_valid) begin
            pc_d    = redirect_addr;
            state_d = run ? FETCH : IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (run) state_d = FETCH;
                end
                FETCH: begin
                    if (!run) begin
                        state_d = IDLE;
                    end else if (!buf_full && occupancy < (CNT_W+1)'(BUF_DEPTH)) begin
                        rd_en = 1'b1;
                        pc_d  = pc_q + 1'b1;
                        if (pc_q == end_addr) state_d = DRAIN;
                    end
                end
                DRAIN: begin
                    if (buf_empty && !inflight_q) state_d = DONE;
                end
                default: state_d = state_q;
            endcase
        end
        inflight_d = rd_en;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
        end
    end

`ifdef IFETCH_RETIRE_COUNT_EN
    logic [15:0] retire_q, retire_d;

    always_comb begin
        retire_d = retire_q;
        if (pop && retire_q != 16'hFFFF) retire_d = retire_q + 16'd1;
    end

    always_ff @(posedge clock) begin
        if (reset) retire_q <= '0;
        else       retire_q <= retire_d;
    end

    assign retire_count = retire_q;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed/randomized bench for instruction_fetch with an address-sequence reference model.
module tb_instruction_fetch;

    localparam int unsigned AW    = 8;
    localparam int unsigned IW    = 16;
    localparam int unsigned DEPTH = 2;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          run = 1'b0;
    logic          redirect_valid = 1'b0;
    logic          iin_ready = 1'b0;
    logic [AW-1:0] end_addr = '0;
    logic [AW-1:0] redirect_addr = '0;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [IW-1:0] mem_rdata = '0;
    logic [IW-1:0] iin;
    logic          iin_valid;
    logic [AW-1:0] pc;
    logic          done;
`ifdef IFETCH_RETIRE_COUNT_EN
    logic [15:0]   retire_count;
`endif

    logic [IW-1:0] rom [256];
    logic [IW-1:0] got [$];
    logic [IW-1:0] exp_q [$];
    logic [AW-1:0] rd_addrs [$];
    int tests = 0;
    int fails = 0;
    int rd_cnt = 0;
    int cyc = 0;
    int first_rd = -1;
    int first_val = -1;
    int model_retire = 0;
    int rd_before;

    instruction_fetch #(
        .ADDR_WIDTH  (AW),
        .INSTR_WIDTH (IW),
        .BUF_DEPTH   (DEPTH)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .run            (run),
        .end_addr       (end_addr),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .mem_rd_en      (mem_rd_en),
        .mem_addr       (mem_addr),
        .mem_rdata      (mem_rdata),
        .iin            (iin),
        .iin_valid      (iin_valid),
        .iin_ready      (iin_ready),
        .pc             (pc),
`ifdef IFETCH_RETIRE_COUNT_EN
        .retire_count   (retire_count),
`endif
        .done           (done)
    );

    always #5 clock = ~clock;

    // Synchronous ROM: data valid the cycle after the strobe.
    always @(posedge clock) begin
        if (mem_rd_en) mem_rdata <= rom[mem_addr];
    end

    // Observer at the falling edge: reads issued and instructions accepted.
    always @(negedge clock) begin
        cyc++;
        if (reset) begin
            model_retire = 0;
        end else begin
            if (mem_rd_en) begin
                rd_cnt++;
                rd_addrs.push_back(mem_addr);
                if (first_rd < 0) first_rd = cyc;
            end
            if (iin_valid && first_val < 0) first_val = cyc;
            if (iin_valid && iin_ready && !redirect_valid) begin
                got.push_back(iin);
                model_retire++;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_obs();
        got.delete();
        rd_addrs.delete();
        rd_cnt    = 0;
        first_rd  = -1;
        first_val = -1;
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        run            = 1'b0;
        redirect_valid = 1'b0;
        iin_ready      = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        clear_obs();
    endtask

    // Program order from start through last, wrapping modulo the address space.
    function automatic void build_exp(input logic [AW-1:0] start, input logic [AW-1:0] last);
        logic [AW-1:0] a;
        a = start;
        exp_q.delete();
        for (int n = 0; n < 256; n++) begin
            exp_q.push_back(rom[a]);
            if (a == last) break;
            a = a + 8'd1;
        end
    endfunction

    task automatic check_seq(input string tag);
        check({tag, "_len"}, 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            check($sformatf("%s[%0d]", tag, i), 32'(got[i]), 32'(exp_q[i]));
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = {8'(i), 8'($urandom)};
        rom[0] = 16'h1000;
        rom[1] = 16'h2001;
        rom[2] = 16'h3002;
        rom[3] = 16'h4003;

        // Straight-line program 0..3
        do_reset();
        check("rst_iin_valid", 32'(iin_valid), 32'd0);
        check("rst_iin", 32'(iin), 32'd0);
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rd_en", 32'(mem_rd_en), 32'd0);
        end_addr = 8'd3;
        run      = 1'b1;
        for (int k = 0; k < 100 && done !== 1'b1; k++) begin
            iin_ready = (k % 4 == 3);
            tick();
        end
        iin_ready = 1'b0;
        check("line_done", 32'(done), 32'd1);
        check("line_valid_after_done", 32'(iin_valid), 32'd0);
        check("line_latency", 32'(first_val - first_rd), 32'd2);
        build_exp(8'd0, 8'd3);
        check_seq("line_seq");

        // Back-pressure
        do_reset();
        end_addr = 8'd200;
        run      = 1'b1;
        for (int k = 0; k < 10; k++) tick();
        check("bp_reads", 32'(rd_cnt), 32'(DEPTH));
        check("bp_iin", 32'(iin), 32'(rom[0]));
        check("bp_valid", 32'(iin_valid), 32'd1);
        check("bp_pc", 32'(pc), 32'd2);

        // Redirect while a read is in flight
        do_reset();
        end_addr = 8'h50;
        run      = 1'b1;
        for (int k = 0; k < 20 && mem_rd_en !== 1'b1; k++) tick();
        check("rdr_first_read", 32'(mem_rd_en), 32'd1);
        tick();
        redirect_valid = 1'b1;
        redirect_addr  = 8'h40;
        tick();
        redirect_valid = 1'b0;
        clear_obs();
        check("rdr_valid_cleared", 32'(iin_valid), 32'd0);
        check("rdr_pc", 32'(pc), 32'h40);
        iin_ready = 1'b1;
        for (int k = 0; k < 40 && got.size() < 3; k++) tick();
        iin_ready = 1'b0;
        check("rdr_count", 32'(got.size() >= 3), 32'd1);
        if (got.size() >= 3 && rd_addrs.size() >= 3) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("rdr_iin[%0d]", i), 32'(got[i]), 32'(rom[8'h40 + i]));
                check($sformatf("rdr_addr[%0d]", i), 32'(rd_addrs[i]), 32'(8'h40 + i));
            end
        end

        // Redirect coincident with iin_ready
        do_reset();
        end_addr = 8'h50;
        run      = 1'b1;
        for (int k = 0; k < 20 && iin_valid !== 1'b1; k++) tick();
        check("coin_valid_seen", 32'(iin_valid), 32'd1);
        iin_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_addr  = 8'h20;
        tick();
        redirect_valid = 1'b0;
        iin_ready      = 1'b0;
        check("coin_flushed", 32'(iin_valid), 32'd0);
        check("coin_no_delivery", 32'(got.size()), 32'd0);
`ifdef IFETCH_RETIRE_COUNT_EN
        check("coin_retire_zero", 32'(retire_count), 32'd0);
`endif
        iin_ready = 1'b1;
        for (int k = 0; k < 40 && got.size() < 2; k++) tick();
        iin_ready = 1'b0;
        build_exp(8'h20, 8'h21);
        check_seq("coin_seq");
`ifdef IFETCH_RETIRE_COUNT_EN
        check("coin_retire", 32'(retire_count), 32'(model_retire));
`endif

        // run toggle with random acceptance
        do_reset();
        end_addr = 8'h0F;
        run      = 1'b1;
        for (int k = 0; k < 8; k++) begin
            iin_ready = 1'($urandom_range(0, 1));
            tick();
        end
        run       = 1'b0;
        rd_before = rd_cnt;
        for (int k = 0; k < 5; k++) begin
            iin_ready = 1'($urandom_range(0, 1));
            tick();
        end
        check("pause_no_reads", 32'(rd_cnt - rd_before), 32'd0);
        run = 1'b1;
        for (int k = 0; k < 400 && done !== 1'b1; k++) begin
            iin_ready = 1'($urandom_range(0, 1));
            tick();
        end
        iin_ready = 1'b0;
        check("pause_done", 32'(done), 32'd1);
        build_exp(8'h00, 8'h0F);
        check_seq("pause_seq");
`ifdef IFETCH_RETIRE_COUNT_EN
        check("pause_retire", 32'(retire_count), 32'(model_retire));
`endif

        // Reset while draining
        do_reset();
        end_addr  = 8'd5;
        run       = 1'b1;
        iin_ready = 1'b1;
        for (int k = 0; k < 40 && !(mem_rd_en === 1'b1 && mem_addr === 8'd5); k++) tick();
        check("drain_last_read", 32'(mem_rd_en && mem_addr == 8'd5), 32'd1);
        iin_ready = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("drain_rst_valid", 32'(iin_valid), 32'd0);
        check("drain_rst_pc", 32'(pc), 32'd0);
        check("drain_rst_done", 32'(done), 32'd0);
        check("drain_rst_idle", 32'(mem_rd_en), 32'd0);
`ifdef IFETCH_RETIRE_COUNT_EN
        check("drain_rst_retire", 32'(retire_count), 32'd0);
`endif
        tick();
        check("drain_restart_rd", 32'(mem_rd_en), 32'd1);
        check("drain_restart_addr", 32'(mem_addr), 32'd0);

        // end_addr below the start PC: fetch wraps
        do_reset();
        redirect_valid = 1'b1;
        redirect_addr  = 8'hFE;
        tick();
        redirect_valid = 1'b0;
        check("wrap_pc", 32'(pc), 32'hFE);
        check("wrap_idle", 32'(mem_rd_en), 32'd0);
        clear_obs();
        end_addr  = 8'h01;
        run       = 1'b1;
        iin_ready = 1'b1;
        for (int k = 0; k < 60 && done !== 1'b1; k++) tick();
        iin_ready = 1'b0;
        check("wrap_done", 32'(done), 32'd1);
        build_exp(8'hFE, 8'h01);
        check_seq("wrap_seq");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
